cache_refill_ctrl: RTL and testbench

CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

---
 rtl/cache_refill_ctrl.sv | 140 ++++++++++++++
 tb/tb_cache_refill_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_refill_ctrl.sv
// Blocking-cache miss handler: optional dirty-victim writeback,
// then line refill from memory, with a bounded ack wait.
module cache_refill_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_WIDTH = 128,
  parameter int TIMEOUT     = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   miss_req,
  input  logic [DATA_WIDTH-1:0]  miss_addr,
  input  logic                   victim_dirty,
  input  logic [DATA_WIDTH-1:0]  victim_addr,
  input  logic [BLOCK_WIDTH-1:0] victim_data,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [DATA_WIDTH-1:0]  mem_addr,
  output logic [BLOCK_WIDTH-1:0] mem_wdata,
  input  logic                   mem_ack,
  input  logic [BLOCK_WIDTH-1:0] mem_rdata,
  output logic                   refill_valid,
  output logic [DATA_WIDTH-1:0]  refill_addr,
  output logic [BLOCK_WIDTH-1:0] refill_data,
  output logic                   stall,
  output logic                   error,
  output logic [DATA_WIDTH-1:0]  miss_count
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [DATA_WIDTH-1:0] ALIGN = ~DATA_WIDTH'(15);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WB,
    S_REFILL,
    S_RESP
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          wait_q, wait_d;
  logic                   err_q, err_d;
  logic [DATA_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  maddr_q, vaddr_q;
  logic [BLOCK_WIDTH-1:0] vdata_q, rdata_q;

  logic accept;
  logic fill;

  assign accept = (state_q == S_IDLE) && miss_req;
  assign fill   = (state_q == S_REFILL) && mem_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      maddr_q <= '0;
      vaddr_q <= '0;
      vdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        maddr_q <= miss_addr & ALIGN;
        vaddr_q <= victim_addr & ALIGN;
        vdata_q <= victim_data;
      end
      if (fill) rdata_q <= mem_rdata;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    refill_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (miss_req) begin
          state_d = victim_dirty ? S_WB : S_REFILL;
          wait_d  = '0;
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end
      end
      S_WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = vaddr_q;
        mem_wdata = vdata_q;
        if (mem_ack) begin
          state_d = S_REFILL;
          wait_d  = '0;
        end else if (wait_q == TO_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_REFILL: begin
        mem_req  = 1'b1;
        mem_addr = maddr_q;
        // ack on the last allowed cycle still completes the refill
        if (mem_ack) begin
          state_d = S_RESP;
          wait_d  = '0;
        end else if (wait_q == TO_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_RESP: begin
        refill_valid = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign refill_addr = refill_valid ? maddr_q : '0;
  assign refill_data = refill_valid ? rdata_q : '0;
  assign stall       = (state_q != S_IDLE) || miss_req;
  assign error       = err_q;
  assign miss_count  = cnt_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Randomized bench for cache_refill_ctrl with a transaction-level
// memory/cache model; a narrow second instance covers counter saturation.
module tb_cache_refill_ctrl;

  localparam int DW = 32;
  localparam int BW = 128;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          miss_req;
  logic [DW-1:0] miss_addr;
  logic          victim_dirty;
  logic [DW-1:0] victim_addr;
  logic [BW-1:0] victim_data;
  logic          mem_req;
  logic          mem_we;
  logic [DW-1:0] mem_addr;
  logic [BW-1:0] mem_wdata;
  logic          mem_ack;
  logic [BW-1:0] mem_rdata;
  logic          refill_valid;
  logic [DW-1:0] refill_addr;
  logic [BW-1:0] refill_data;
  logic          stall;
  logic          error;
  logic [DW-1:0] miss_count;

  logic        s_rst;
  logic        s_miss_req;
  logic        s_mem_req, s_mem_we, s_refill_valid, s_stall, s_error;
  logic [7:0]  s_mem_addr, s_refill_addr, s_miss_count;
  logic [31:0] s_mem_wdata, s_refill_data;
  int          s_pulses;

  always #5 clk = ~clk;

  cache_refill_ctrl #(.DATA_WIDTH(DW), .BLOCK_WIDTH(BW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .miss_req(miss_req), .miss_addr(miss_addr),
    .victim_dirty(victim_dirty), .victim_addr(victim_addr),
    .victim_data(victim_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .refill_valid(refill_valid), .refill_addr(refill_addr),
    .refill_data(refill_data), .stall(stall), .error(error),
    .miss_count(miss_count)
  );

  cache_refill_ctrl #(.DATA_WIDTH(8), .BLOCK_WIDTH(32), .TIMEOUT(4)) sat (
    .clk(clk), .rst(s_rst),
    .miss_req(s_miss_req), .miss_addr(8'h5A),
    .victim_dirty(1'b0), .victim_addr(8'h00),
    .victim_data(32'h0),
    .mem_req(s_mem_req), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
    .mem_wdata(s_mem_wdata), .mem_ack(1'b1), .mem_rdata(32'hCAFE_F00D),
    .refill_valid(s_refill_valid), .refill_addr(s_refill_addr),
    .refill_data(s_refill_data), .stall(s_stall), .error(s_error),
    .miss_count(s_miss_count)
  );

  always @(negedge clk) begin
    if (s_rst) s_pulses <= 0;
    else if (s_refill_valid) s_pulses <= s_pulses + 1;
  end

  int n_chk  = 0;
  int n_pass = 0;
  logic [DW-1:0] exp_cnt;
  logic          exp_err;

  task automatic chk(input string tag, input logic [BW-1:0] got,
                     input logic [BW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [BW-1:0] rnd_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic scramble();
    miss_addr    = $urandom;
    victim_addr  = $urandom;
    victim_data  = rnd_blk();
    victim_dirty = 1'($urandom);
  endtask

  task automatic idle_cycle();
    miss_req = 1'b0;
    mem_ack  = 1'($urandom);
    #1;
    chk("idle_stall", stall, 0);
    chk("idle_req", mem_req, 0);
    chk("idle_rv", refill_valid, 0);
    chk("idle_addr", mem_addr, 0);
    @(negedge clk);
  endtask

  // One miss: IDLE accept, optional writeback, refill (or timeout), respond.
  task automatic do_miss(input logic [DW-1:0] ma, input logic [DW-1:0] va,
                         input bit dirty, input int wbw, input int rfw,
                         input bit tmo, input bit b2b);
    logic [BW-1:0] vd, rd;
    int st, exp_st;
    vd = rnd_blk();
    rd = '0;
    st = 0;
    miss_req = 1'b1;
    miss_addr = ma;
    victim_dirty = dirty;
    victim_addr = va;
    victim_data = vd;
    mem_ack = 1'b0;
    #1;
    if (stall) st++;
    chk("acc_req", mem_req, 0);
    @(negedge clk);
    if (exp_cnt != '1) exp_cnt++;
    if (dirty) begin
      for (int i = 0; i <= wbw; i++) begin
        scramble();
        mem_ack = (i == wbw);
        mem_rdata = rnd_blk();
        #1;
        if (stall) st++;
        chk("wb_req", mem_req, 1);
        chk("wb_we", mem_we, 1);
        chk("wb_addr", mem_addr, va & ~32'hF);
        chk("wb_wdata", mem_wdata, vd);
        @(negedge clk);
      end
    end
    for (int i = 0; i < TO; i++) begin
      if (!tmo && i > rfw) break;
      scramble();
      mem_ack = !tmo && (i == rfw);
      rd = rnd_blk();
      mem_rdata = rd;
      if (tmo && i == TO - 1) miss_req = 1'b0;
      #1;
      if (stall) st++;
      chk("rf_req", mem_req, 1);
      chk("rf_we", mem_we, 0);
      chk("rf_addr", mem_addr, ma & ~32'hF);
      @(negedge clk);
    end
    exp_st = 1 + (dirty ? wbw + 1 : 0) + (tmo ? TO : rfw + 2);
    if (tmo) begin
      exp_err = 1'b1;
      mem_ack = 1'b0;
      #1;
      chk("to_err", error, 1);
      chk("to_req", mem_req, 0);
      chk("to_rv", refill_valid, 0);
      chk("to_stall", stall, 0);
    end else begin
      miss_req = b2b;
      mem_ack = 1'($urandom);
      miss_addr = $urandom;
      #1;
      if (stall) st++;
      chk("rsp_rv", refill_valid, 1);
      chk("rsp_addr", refill_addr, ma & ~32'hF);
      chk("rsp_data", refill_data, rd);
      chk("rsp_req", mem_req, 0);
      chk("rsp_maddr", mem_addr, 0);
      chk("rsp_wdata", mem_wdata, 0);
    end
    chk("stall_cyc", st, exp_st);
    chk("miss_cnt", miss_count, exp_cnt);
    chk("err", error, exp_err);
    @(negedge clk);
  endtask

  initial begin
    bit b2b;
    rst = 1'b1;
    s_rst = 1'b1;
    s_miss_req = 1'b0;
    miss_req = 1'b0;
    miss_addr = '0;
    victim_dirty = 1'b0;
    victim_addr = '0;
    victim_data = '0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    exp_cnt = '0;
    exp_err = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rv", refill_valid, 0);
    chk("rst_raddr", refill_addr, 0);
    chk("rst_rdata", refill_data, 0);
    chk("rst_err", error, 0);
    chk("rst_cnt", miss_count, 0);
    chk("rst_stall", stall, 0);
    miss_req = 1'b1;
    #1;
    chk("rst_stall_miss", stall, 1);
    miss_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    s_rst = 1'b0;
    s_miss_req = 1'b1;

    do_miss(32'h0000_1234, $urandom, 0, 0, 0, 0, 0);
    idle_cycle();
    do_miss($urandom, 32'h0000_2008, 1, 2, 2, 0, 0);
    idle_cycle();
    do_miss($urandom, $urandom, 0, 0, 0, 1, 0);
    idle_cycle();
    do_miss($urandom, $urandom, 0, 0, TO - 1, 0, 0);
    idle_cycle();
    do_miss($urandom, $urandom, 1, 0, 1, 0, 1);
    do_miss($urandom, $urandom, 0, 1, 0, 0, 0);
    idle_cycle();

    // reset while a writeback is waiting for ack
    miss_req = 1'b1;
    miss_addr = $urandom;
    victim_dirty = 1'b1;
    victim_addr = $urandom;
    victim_data = rnd_blk();
    mem_ack = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_wb_req", mem_req, 1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("mrst_req", mem_req, 0);
    chk("mrst_stall", stall, 1);
    chk("mrst_cnt", miss_count, 0);
    chk("mrst_err", error, 0);
    rst = 1'b0;
    miss_req = 1'b0;
    exp_cnt = '0;
    exp_err = 1'b0;
    @(negedge clk);
    idle_cycle();

    for (int n = 0; n < 40; n++) begin
      b2b = 1'($urandom);
      do_miss($urandom, $urandom, 1'($urandom), $urandom_range(0, 3),
              $urandom_range(0, 3), ($urandom_range(0, 9) == 0), b2b);
      if (!b2b) idle_cycle();
    end
    idle_cycle();

    repeat (850) @(negedge clk);
    s_miss_req = 1'b0;
    repeat (4) @(negedge clk);
    chk("sat_model", s_miss_count, (s_pulses > 255) ? 255 : s_pulses);
    chk("sat_ff", s_miss_count, 8'hFF);
    chk("sat_err", s_error, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
